// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, engine state encoding and the FIPS 180-4 round functions.
package sha256_pkg;
   localparam int WORD_W = 32;
   localparam int ROUNDS = 64;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [0:7][WORD_W-1:0] hash_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam hash_t IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [0:ROUNDS-1][WORD_W-1:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

   function automatic word_t e0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t e1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t s0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t s1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic word_t maj(input word_t x, input word_t y, input word_t z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction
endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word message schedule window: parallel load of a block, then one shift and
// one new schedule word per round. W[0] is the word consumed by the current round.
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [511:0] blk_i,
   input  logic         shift_i,
   output word_t        w0_o
);
   word_t w_q [16];
   word_t w_d [16];
   word_t w_new;

   assign w_new = s1(w_q[14]) + w_q[9] + s0(w_q[1]) + w_q[0];
   assign w0_o  = w_q[0];

   always_comb begin
      w_d = w_q;
      if (load_i) begin
         for (int i = 0; i < 16; i++) begin
            w_d[i] = blk_i[511 - 32*i -: 32];
         end
      end else if (shift_i) begin
         for (int i = 0; i < 15; i++) begin
            w_d[i] = w_q[i+1];
         end
         w_d[15] = w_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            w_q[i] <= '0;
         end
      end else begin
         w_q <= w_d;
      end
   end
endmodule

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression engine: one round per clock, hash chained across blocks,
// digest presented straight from the H register on a valid/ready port.
module sha256_compress_ctrl
   import sha256_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] blk_data,
   input  logic         blk_first,
   output logic         dig_valid,
   input  logic         dig_ready,
   output logic [255:0] dig_data,
   output logic         busy
);
   localparam logic [5:0] R_LAST = 6'(ROUNDS - 1);

   state_t     state_q, state_d;
   logic [5:0] r_q, r_d;
   hash_t      h_q, h_d;
   hash_t      v_q, v_d;
   logic       accept;
   word_t      w0, t1, t2;

   assign accept = blk_valid && (state_q == IDLE);

   sha256_msg_sched u_sched (
      .clk     (clk),
      .rst     (rst),
      .load_i  (accept),
      .blk_i   (blk_data),
      .shift_i (state_q == ROUND),
      .w0_o    (w0)
   );

   // v_q holds a..h in index order 0..7
   assign t1 = v_q[7] + e1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K[r_q] + w0;
   assign t2 = e0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      h_d     = h_q;
      v_d     = v_q;
      case (state_q)
         IDLE: begin
            if (blk_valid) begin
               state_d = ROUND;
               r_d     = '0;
               if (blk_first) h_d = IV;
               v_d = blk_first ? IV : h_q;
            end
         end
         ROUND: begin
            v_d = {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
            if (r_q == R_LAST) state_d = FINAL;
            else               r_d     = r_q + 6'd1;
         end
         FINAL: begin
            for (int i = 0; i < 8; i++) begin
               h_d[i] = h_q[i] + v_q[i];
            end
            state_d = DONE;
         end
         DONE: begin
            if (dig_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         h_q     <= IV;
         v_q     <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   assign blk_ready = (state_q == IDLE);
   assign dig_valid = (state_q == DONE);
   assign busy      = (state_q == ROUND) || (state_q == FINAL);
   assign dig_data  = h_q;
endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Directed bench for sha256_compress_ctrl using known FIPS 180-4 digests.
module tb_sha256_compress_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         dig_valid;
   logic         dig_ready;
   logic [255:0] dig_data;
   logic         busy;

   int checks = 0;
   int errors = 0;

   localparam logic [255:0] IV_DIG    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [511:0] TWO_BLK1  = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};
   localparam logic [255:0] TWO_MID   = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
   localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   sha256_compress_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .dig_valid (dig_valid),
      .dig_ready (dig_ready),
      .dig_data  (dig_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Called at a negedge with blk_ready high; returns at the negedge after the accept edge.
   task automatic accept_block(input logic [511:0] d, input logic first);
      blk_data  = d;
      blk_first = first;
      blk_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      blk_valid = 1'b0;
   endtask

   // lat counts edges after the accept edge until dig_valid is seen.
   task automatic wait_digest(output int lat, output logic busy0, output logic busy64);
      lat    = 0;
      busy0  = busy;
      busy64 = 1'b0;
      while (!dig_valid && lat < 200) begin
         @(negedge clk);
         lat++;
         if (lat == 64) busy64 = busy;
      end
   endtask

   task automatic take_digest(input string tag, input logic [255:0] exp);
      chk(tag, dig_data, exp);
      dig_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dig_ready = 1'b0;
      chk({tag, "_ready_after"}, {255'h0, blk_ready}, 256'h1);
   endtask

   initial begin
      int   lat;
      logic b0, b64;
      rst       = 1'b1;
      blk_valid = 1'b0;
      blk_data  = '0;
      blk_first = 1'b0;
      dig_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_blk_ready", {255'h0, blk_ready}, 256'h1);
      chk("rst_dig_valid", {255'h0, dig_valid}, 256'h0);
      chk("rst_busy",      {255'h0, busy},      256'h0);
      chk("rst_dig_data",  dig_data,            IV_DIG);
      rst = 1'b0;
      @(negedge clk);

      accept_block(ABC_BLK, 1'b1);
      wait_digest(lat, b0, b64);
      chk("abc_latency", 256'(lat), 256'd65);
      chk("abc_busy_c0", {255'h0, b0},  256'h1);
      chk("abc_busy_c64", {255'h0, b64}, 256'h1);
      chk("abc_busy_done", {255'h0, busy}, 256'h0);
      take_digest("abc", ABC_DIG);

      accept_block(EMPTY_BLK, 1'b1);
      wait_digest(lat, b0, b64);
      chk("empty_latency", 256'(lat), 256'd65);
      take_digest("empty", EMPTY_DIG);

      accept_block(TWO_BLK1, 1'b1);
      wait_digest(lat, b0, b64);
      take_digest("two_mid", TWO_MID);
      accept_block(TWO_BLK2, 1'b0);
      wait_digest(lat, b0, b64);
      chk("two_latency", 256'(lat), 256'd65);
      take_digest("two_final", TWO_DIG);

      accept_block(ABC_BLK, 1'b1);
      wait_digest(lat, b0, b64);
      blk_data  = EMPTY_BLK;
      blk_first = 1'b1;
      blk_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_dig_valid", {255'h0, dig_valid}, 256'h1);
         chk("bp_dig_data",  dig_data,            ABC_DIG);
         chk("bp_blk_ready", {255'h0, blk_ready}, 256'h0);
         @(negedge clk);
      end
      dig_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dig_ready = 1'b0;
      chk("bp_ready_after_hs", {255'h0, blk_ready}, 256'h1);
      chk("bp_not_busy_hs",    {255'h0, busy},      256'h0);
      chk("bp_valid_drop",     {255'h0, dig_valid}, 256'h0);
      @(posedge clk);
      @(negedge clk);
      blk_valid = 1'b0;
      chk("bp_accept_next", {255'h0, busy}, 256'h1);
      wait_digest(lat, b0, b64);
      chk("bp_latency", 256'(lat), 256'd65);
      take_digest("bp_empty", EMPTY_DIG);

      accept_block(ABC_BLK, 1'b1);
      repeat (30) @(negedge clk);
      chk("mid_busy_pre", {255'h0, busy}, 256'h1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_blk_ready", {255'h0, blk_ready}, 256'h1);
      chk("mid_rst_dig_valid", {255'h0, dig_valid}, 256'h0);
      chk("mid_rst_busy",      {255'h0, busy},      256'h0);
      chk("mid_rst_dig_data",  dig_data,            IV_DIG);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      accept_block(ABC_BLK, 1'b0);
      wait_digest(lat, b0, b64);
      chk("post_rst_latency", 256'(lat), 256'd65);
      take_digest("post_rst_abc", ABC_DIG);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
